// File: rtl/switch_pkg.sv
// Shared types for the VecCore switch: lane/vector types, scheduler states, index width helper.
// Used by switch_sched, the switch datapath and the VecCore side.
package switch_pkg;

   typedef logic [31:0] lane_t;
   typedef lane_t [15:0] vec_t;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } sched_state_e;

   // Width of an index into n entries; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/switch_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
// Outputs a one-hot grant and its index; no grant (all zero) when req is empty.
module rr_arbiter
   import switch_pkg::*;
#(
   parameter int  N  = 2,
   localparam int IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic          found;
   logic [IW-1:0] cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int k = 0; k < N; k++) begin
         cand = IW'((int'(ptr) + k) % N);
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/switch_sched.sv
// Round-robin scheduler for core-to-core transfers over one shared lane bus; one grant per two cycles.
// Optional per-core transfer and stall-cycle counters under SWITCH_SCHED_STATS_EN.
module switch_sched
   import switch_pkg::*;
#(
   parameter int  CORE_SIZE      = 2,
   parameter int  WIDTH          = 16,
   parameter int  STALL_LIMIT    = 1024,
   localparam int CORE_ADDR_SIZE = idx_width(CORE_SIZE)
) (
   input  logic                                        clock,
   input  logic                                        reset,
   input  logic [CORE_SIZE-1:0]                        send_ready,
   input  logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0]    send_core_idx,
   input  lane_t [CORE_SIZE-1:0][WIDTH-1:0]            send_data,
   output logic [CORE_SIZE-1:0]                        send_ok,
   input  logic [CORE_SIZE-1:0]                        recv_request,
   input  logic [CORE_SIZE-1:0][CORE_ADDR_SIZE-1:0]    recv_core_idx,
   output logic [CORE_SIZE-1:0]                        recv_ready,
   output lane_t [CORE_SIZE-1:0][WIDTH-1:0]            recv_data,
   output logic                                        busy,
   output logic                                        stall_err
`ifdef SWITCH_SCHED_STATS_EN
   ,
   output logic [CORE_SIZE-1:0][31:0]                  xfer_count,
   output logic [31:0]                                 stall_cycles
`endif
);

   localparam int SCW = idx_width(STALL_LIMIT);

   sched_state_e              state, state_d;
   logic [CORE_SIZE-1:0]      match;
   logic [CORE_SIZE-1:0]      gnt;
   logic [CORE_ADDR_SIZE-1:0] gnt_idx;
   logic [CORE_ADDR_SIZE-1:0] dst_sel;
   logic [CORE_ADDR_SIZE-1:0] rr_ptr;
   logic [CORE_ADDR_SIZE-1:0] src;
   logic                      grant;
   logic [CORE_SIZE-1:0]      send_ok_d;
   logic [CORE_SIZE-1:0]      recv_ready_d;
   logic                      pending;
   logic                      stall_inc;
   logic [SCW-1:0]            stall_cnt;

   // Only in-range, non-self pairs that name each other can match.
   always_comb begin
      match = '0;
      for (int i = 0; i < CORE_SIZE; i++) begin
         for (int j = 0; j < CORE_SIZE; j++) begin
            if (i != j && send_ready[i] && recv_request[j] &&
                send_core_idx[i] == CORE_ADDR_SIZE'(j) &&
                recv_core_idx[j] == CORE_ADDR_SIZE'(i)) begin
               match[i] = 1'b1;
            end
         end
      end
   end

   rr_arbiter #(.N(CORE_SIZE)) u_arb (
      .req     (match),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign dst_sel   = send_core_idx[gnt_idx];
   assign pending   = (|send_ready) || (|recv_request);
   assign stall_inc = (state == IDLE) && pending && !(|match);

   always_ff @(posedge clock) begin
      if (!reset) state <= IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (|match) state_d = XFER;
         XFER:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant        = (state == IDLE) && (|match);
      send_ok_d    = '0;
      recv_ready_d = '0;
      if (grant) begin
         send_ok_d             = gnt;
         recv_ready_d[dst_sel] = 1'b1;
      end
      busy = (state == XFER);
   end

   // The receiver's hold register is the bus latch, so data lands together with the pulses.
   always_ff @(posedge clock) begin
      if (!reset) begin
         send_ok    <= '0;
         recv_ready <= '0;
         recv_data  <= '0;
         rr_ptr     <= '0;
         src        <= '0;
      end else begin
         send_ok    <= send_ok_d;
         recv_ready <= recv_ready_d;
         if (grant) begin
            recv_data[dst_sel] <= send_data[gnt_idx];
            src                <= gnt_idx;
         end
         if (state == XFER) begin
            rr_ptr <= (src == CORE_ADDR_SIZE'(CORE_SIZE - 1)) ? '0 : src + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         stall_cnt <= '0;
         stall_err <= 1'b0;
      end else if (stall_inc) begin
         if (stall_cnt == SCW'(STALL_LIMIT - 1)) stall_err <= 1'b1;
         else                                    stall_cnt <= stall_cnt + 1'b1;
      end else if (state == IDLE) begin
         stall_cnt <= '0;
      end
   end

`ifdef SWITCH_SCHED_STATS_EN
   always_ff @(posedge clock) begin
      if (!reset) begin
         xfer_count   <= '0;
         stall_cycles <= '0;
      end else begin
         if (state == XFER) xfer_count[src] <= xfer_count[src] + 32'd1;
         if (stall_inc)     stall_cycles    <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_switch_sched.sv
// Scoreboard bench for switch_sched: a 2-core instance for the main scenarios, a 4-core one for fan-in.
// Stimulus pushes expected deliveries; per-instance monitors pop and compare on every pulse.
module tb_switch_sched;
   import switch_pkg::*;

   typedef struct {
      logic [3:0] ok;
      logic [3:0] rdy;
      int         dst;
      vec_t       data;
   } exp_t;

   localparam lane_t FP [16] = '{
      32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
      32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000,
      32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000,
      32'h41400000, 32'h41500000, 32'h41600000, 32'h41700000};

   logic clk;
   logic rst_n;

   logic [1:0]       sr_a, ok_a, rq_a, rdy_a;
   logic [1:0][0:0]  sidx_a, ridx_a;
   vec_t [1:0]       sd_a, rd_a;
   logic             busy_a, err_a;

   logic [3:0]       sr_b, ok_b, rq_b, rdy_b;
   logic [3:0][1:0]  sidx_b, ridx_b;
   vec_t [3:0]       sd_b, rd_b;
   logic             busy_b, err_b;

`ifdef SWITCH_SCHED_STATS_EN
   logic [1:0][31:0] xc_a;
   logic [31:0]      sc_a;
   logic [3:0][31:0] xc_b;
   logic [31:0]      sc_b;
`endif

   int total = 0;
   int bad   = 0;
   exp_t exp_a[$];
   exp_t exp_b[$];

   switch_sched #(.CORE_SIZE(2), .WIDTH(16), .STALL_LIMIT(8)) dut_a (
      .clock(clk), .reset(rst_n),
      .send_ready(sr_a), .send_core_idx(sidx_a), .send_data(sd_a), .send_ok(ok_a),
      .recv_request(rq_a), .recv_core_idx(ridx_a), .recv_ready(rdy_a), .recv_data(rd_a),
      .busy(busy_a), .stall_err(err_a)
`ifdef SWITCH_SCHED_STATS_EN
      , .xfer_count(xc_a), .stall_cycles(sc_a)
`endif
   );

   switch_sched #(.CORE_SIZE(4), .WIDTH(16), .STALL_LIMIT(8)) dut_b (
      .clock(clk), .reset(rst_n),
      .send_ready(sr_b), .send_core_idx(sidx_b), .send_data(sd_b), .send_ok(ok_b),
      .recv_request(rq_b), .recv_core_idx(ridx_b), .recv_ready(rdy_b), .recv_data(rd_b),
      .busy(busy_b), .stall_err(err_b)
`ifdef SWITCH_SCHED_STATS_EN
      , .xfer_count(xc_b), .stall_cycles(sc_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout act=running req=finished");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s act=%0h req=%0h", name, act, req);
      end
   endtask

   function automatic vec_t pat(input logic [31:0] base);
      vec_t r;
      for (int k = 0; k < 16; k++) r[k] = base + 32'(k);
      return r;
   endfunction

   function automatic vec_t fpvec();
      vec_t r;
      for (int k = 0; k < 16; k++) r[k] = FP[k];
      return r;
   endfunction

   function automatic exp_t mk(input int s, input int d, input vec_t v);
      exp_t e;
      e.ok   = 4'(1 << s);
      e.rdy  = 4'(1 << d);
      e.dst  = d;
      e.data = v;
      return e;
   endfunction

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (ok_a != 2'b00 || rdy_a != 2'b00) begin
         total++;
         if (exp_a.size() == 0) begin
            bad++;
            $display("FAIL pulse_a act=ok:%b,rdy:%b req=no_pulse", ok_a, rdy_a);
         end else begin
            e = exp_a.pop_front();
            if (ok_a !== e.ok[1:0] || rdy_a !== e.rdy[1:0] || rd_a[e.dst] !== e.data) begin
               bad++;
               $display("FAIL pulse_a act=ok:%b,rdy:%b,data:%h req=ok:%b,rdy:%b,data:%h",
                        ok_a, rdy_a, rd_a[e.dst], e.ok[1:0], e.rdy[1:0], e.data);
            end
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (ok_b != 4'b0 || rdy_b != 4'b0) begin
         total++;
         if (exp_b.size() == 0) begin
            bad++;
            $display("FAIL pulse_b act=ok:%b,rdy:%b req=no_pulse", ok_b, rdy_b);
         end else begin
            e = exp_b.pop_front();
            if (ok_b !== e.ok || rdy_b !== e.rdy || rd_b[e.dst] !== e.data) begin
               bad++;
               $display("FAIL pulse_b act=ok:%b,rdy:%b,data:%h req=ok:%b,rdy:%b,data:%h",
                        ok_b, rdy_b, rd_b[e.dst], e.ok, e.rdy, e.data);
            end
         end
      end
   end

   // Single transfer s->d on instance A, launched at a negedge; returns at the negedge after the pulse.
   task automatic xfer_a(input int s, input int d, input vec_t v);
      sr_a[s] = 1'b1; sidx_a[s] = d[0:0]; sd_a[s] = v;
      rq_a[d] = 1'b1; ridx_a[d] = s[0:0];
      exp_a.push_back(mk(s, d, v));
      @(negedge clk);
      chk("xfer_busy_hi", 32'(busy_a), 32'd1);
      sr_a[s] = 1'b0; rq_a[d] = 1'b0;
      @(negedge clk);
      chk("xfer_busy_lo", 32'(busy_a), 32'd0);
   endtask

   task automatic crossed(input int first, input vec_t v0, input vec_t v1);
      int other;
      other = 1 - first;
      sr_a = 2'b11; sidx_a[0] = 1'b1; sidx_a[1] = 1'b0; sd_a[0] = v0; sd_a[1] = v1;
      rq_a = 2'b11; ridx_a[0] = 1'b1; ridx_a[1] = 1'b0;
      exp_a.push_back(mk(first, other, (first == 0) ? v0 : v1));
      exp_a.push_back(mk(other, first, (first == 0) ? v1 : v0));
      @(negedge clk);
      chk("cross_busy1", 32'(busy_a), 32'd1);
      sr_a[first] = 1'b0; rq_a[other] = 1'b0;
      @(negedge clk);
      chk("cross_gap", 32'(busy_a), 32'd0);
      @(negedge clk);
      chk("cross_busy2", 32'(busy_a), 32'd1);
      sr_a = 2'b00; rq_a = 2'b00;
      @(negedge clk);
      chk("cross_done", 32'(busy_a), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      sr_a = '0; sidx_a = '0; sd_a = '0; rq_a = '0; ridx_a = '0;
      sr_b = '0; sidx_b = '0; sd_b = '0; rq_b = '0; ridx_b = '0;

      // Reset held with a live 0->1 match: nothing may come out.
      sr_a[0] = 1'b1; sidx_a[0] = 1'b1; sd_a[0] = pat(32'h1000_0000);
      rq_a[1] = 1'b1; ridx_a[1] = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("rst_send_ok", 32'(ok_a), 32'd0);
         chk("rst_recv_ready", 32'(rdy_a), 32'd0);
         chk("rst_busy", 32'(busy_a), 32'd0);
         chk("rst_stall_err", 32'(err_a), 32'd0);
         chk("rst_recv_data", 32'(rd_a != '0), 32'd0);
      end
      chk("rst_b_quiet", 32'({busy_b, err_b, ok_b, rdy_b}), 32'd0);
      exp_a.push_back(mk(0, 1, pat(32'h1000_0000)));
      rst_n = 1'b1;
      @(negedge clk);
      chk("release_busy", 32'(busy_a), 32'd1);
      sr_a = '0; rq_a = '0;
      @(negedge clk);
      chk("release_idle", 32'(busy_a), 32'd0);

      // Basic transfer with lanes k*1.0, then the reverse direction.
      xfer_a(0, 1, fpvec());
      chk("basic_rd0_untouched", 32'(rd_a[0] != '0), 32'd0);
      xfer_a(1, 0, pat(32'h2000_0000));

      // Crossed pairs from rr_ptr=0, then from rr_ptr=1 after a lone 0->1.
      crossed(0, pat(32'h3000_0000), pat(32'h3100_0000));
      xfer_a(0, 1, pat(32'h3200_0000));
      crossed(1, pat(32'h3300_0000), pat(32'h3400_0000));

      // Receiver names itself: no match, watchdog trips on the 8th unmatched cycle.
      sr_a[0] = 1'b1; sidx_a[0] = 1'b1; sd_a[0] = pat(32'h4000_0000);
      rq_a[1] = 1'b1; ridx_a[1] = 1'b1;
      repeat (7) @(negedge clk);
      chk("stall_err_before_limit", 32'(err_a), 32'd0);
      @(negedge clk);
      chk("stall_err_at_limit", 32'(err_a), 32'd1);
      chk("stall_no_busy", 32'(busy_a), 32'd0);
`ifdef SWITCH_SCHED_STATS_EN
      chk("stall_cycles", sc_a, 32'd8);
`endif
      ridx_a[1] = 1'b0;
      exp_a.push_back(mk(0, 1, pat(32'h4000_0000)));
      @(negedge clk);
      chk("stall_fixed_busy", 32'(busy_a), 32'd1);
      sr_a = '0; rq_a = '0;
      @(negedge clk);
      chk("stall_err_sticky", 32'(err_a), 32'd1);

      // Reset sampled on the edge that would launch the transfer.
      sr_a[0] = 1'b1; sidx_a[0] = 1'b1; sd_a[0] = pat(32'h5000_0000);
      rq_a[1] = 1'b1; ridx_a[1] = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_send_ok", 32'(ok_a), 32'd0);
      chk("abort_recv_ready", 32'(rdy_a), 32'd0);
      chk("abort_busy", 32'(busy_a), 32'd0);
      chk("abort_recv_data", 32'(rd_a != '0), 32'd0);
      chk("abort_stall_err", 32'(err_a), 32'd0);
      sr_a = '0; rq_a = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_quiet", 32'({busy_a, ok_a, rdy_a}), 32'd0);

      // Four cores: 0,1,2 all target core 3, which names 2 then 0.
      for (int i = 0; i < 3; i++) begin
         sr_b[i] = 1'b1; sidx_b[i] = 2'd3; sd_b[i] = pat(32'h6000_0000 + 32'(i) * 32'h100);
      end
      rq_b[3] = 1'b1; ridx_b[3] = 2'd2;
      exp_b.push_back(mk(2, 3, pat(32'h6000_0200)));
      @(negedge clk);
      chk("fanin_busy1", 32'(busy_b), 32'd1);
      sr_b[2] = 1'b0; ridx_b[3] = 2'd0;
      exp_b.push_back(mk(0, 3, pat(32'h6000_0000)));
      @(negedge clk);
      chk("fanin_gap", 32'(busy_b), 32'd0);
      @(negedge clk);
      chk("fanin_busy2", 32'(busy_b), 32'd1);
      sr_b = '0; rq_b = '0;
      @(negedge clk);
      chk("fanin_done", 32'(busy_b), 32'd0);
`ifdef SWITCH_SCHED_STATS_EN
      chk("xfer_count0", xc_b[0], 32'd1);
      chk("xfer_count1", xc_b[1], 32'd0);
      chk("xfer_count2", xc_b[2], 32'd1);
      chk("xfer_count3", xc_b[3], 32'd0);
`endif

      repeat (2) @(negedge clk);
      chk("exp_a_drained", 32'(exp_a.size()), 32'd0);
      chk("exp_b_drained", 32'(exp_b.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
